lif_spike_layer: RTL

LIF_SPIKE_LAYER -- requirements
Module: lif_spike_layer

---
 rtl/lif_spike_layer.sv | 116 +++++++++++
 1 files changed

// File: rtl/lif_spike_layer.sv
// lif_spike_layer: four leaky integrate-and-fire neurons fed by a toggle-strobed
// word stream. Four words are collected, one parallel update produces a spike
// vector, and the vector is held until downstream accepts it.
// Optional build macro: LIF_REFRACTORY_EN (a neuron that fired sits out the next update).
//
// state   | meaning
// --------+---------------------------------------------------------------
// COLLECT | waiting for word events, filling word[0..3]
// UPDATE  | one cycle: integrate, leak, fire for all four neurons
// EMIT    | spike_vec valid, waiting for spike_ready
module lif_spike_layer #(
  parameter logic [7:0] THRESH = 8'd128,
  parameter logic [7:0] LEAK   = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_val,
  input  logic       in_toggle,
  input  logic       spike_ready,
  output logic [3:0] spike_vec,
  output logic       spike_valid,
  output logic       in_busy,
  output logic       drop_err
);

  typedef enum logic [1:0] {COLLECT, UPDATE, EMIT} state_t;

  state_t     state, state_nxt;
  logic       tog_q;
  logic       word_evt;
  logic [1:0] idx;
  logic [7:0] word [4];
  logic [7:0] pot  [4];
  logic [7:0] pot_nxt [4];
  logic [8:0] sum9 [4];
  logic [7:0] sat  [4];
  logic [7:0] leaked [4];
  logic [3:0] fire_nxt;
`ifdef LIF_REFRACTORY_EN
  logic [3:0] refr;
`endif

  assign word_evt    = in_toggle ^ tog_q;
  assign spike_valid = (state == EMIT);
  assign in_busy     = (state != COLLECT);

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (word_evt && idx == 2'd3) state_nxt = UPDATE;
      UPDATE:  state_nxt = EMIT;
      EMIT:    if (spike_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // neuron datapath: saturating integrate, floor-at-zero leak, threshold
  always_comb begin
    fire_nxt = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      sum9[k]    = {1'b0, pot[k]} + {1'b0, word[k]};
      sat[k]     = sum9[k][8] ? 8'hFF : sum9[k][7:0];
      leaked[k]  = (sat[k] > LEAK) ? (sat[k] - LEAK) : 8'd0;
      fire_nxt[k] = (leaked[k] >= THRESH);
      pot_nxt[k] = fire_nxt[k] ? 8'd0 : leaked[k];
`ifdef LIF_REFRACTORY_EN
      if (refr[k]) begin
        fire_nxt[k] = 1'b0;
        pot_nxt[k]  = 8'd0;
      end
`endif
    end
  end

  // state, strobe edge detect, word capture and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      tog_q    <= 1'b0;
      idx      <= 2'd0;
      drop_err <= 1'b0;
      for (int k = 0; k < 4; k++) word[k] <= 8'd0;
    end else begin
      state <= state_nxt;
      tog_q <= in_toggle;
      if (word_evt) begin
        if (state == COLLECT) begin
          word[idx] <= in_val;
          idx       <= idx + 2'd1;
        end else begin
          drop_err <= 1'b1;
        end
      end
    end
  end

  // potentials and spike vector change only in UPDATE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_vec <= 4'b0000;
      for (int k = 0; k < 4; k++) pot[k] <= 8'd0;
`ifdef LIF_REFRACTORY_EN
      refr <= 4'b0000;
`endif
    end else if (state == UPDATE) begin
      spike_vec <= fire_nxt;
      for (int k = 0; k < 4; k++) pot[k] <= pot_nxt[k];
`ifdef LIF_REFRACTORY_EN
      // fire_nxt is forced low for refractory neurons, so this also clears them
      refr <= fire_nxt;
`endif
    end
  end

endmodule
